ex_result_stage: RTL and testbench
==================================

// Module: ex_result_stage
// PURPOSE
//  EX/MEM pipeline stage directly downstream of the 32-bit ALU. Registers ALU result/flags with
//  destination info, resolves BEQ/BNE from iszero, and converts signed-ADD overflow into a
//  precise exception. Valid/ready handshake both sides; 2-entry skid buffer keeps in_ready registered.
// PARAMETERS
//  DW   32  datapath width (result, pc)
//  RW    5  register-address width
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  in_valid      in   1   ALU output carries an instruction
//  in_ready      out  1   stage can accept; registered
//  alu_result    in   DW  ALU result
//  alu_iszero    in   1   ALU zero flag
//  alu_overflow  in   1   ALU overflow flag (asserted only for ADD)
//  in_rd         in   RW  destination register
//  in_reg_write  in   1   instruction writes rd
//  in_br_eq      in   1   instruction is BEQ (ALU did SUB)
//  in_br_ne      in   1   instruction is BNE (ALU did SUB)
//  in_pc         in   DW  pc of instruction
//  in_br_target  in   DW  precomputed branch target
//  flush         in   1   discard all held entries
//  out_valid     out  1   head entry valid toward MEM
//  out_ready     in   1   MEM accepts head
//  out_result    out  DW  head result
//  out_rd        out  RW  head destination
//  out_reg_write out  1   head write enable (0 if excepted)
//  br_taken      out  1   1-cycle pulse: accepted branch is taken
//  br_target     out  DW  valid with br_taken
//  exc_valid     out  1   overflow exception pending (level)
//  exc_pc        out  DW  pc of overflowing instruction
//  exc_ack       in   1   exception handler acknowledges; clears exc_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): both entries invalid; in_ready=1; out_valid, br_taken, exc_valid=0;
//   out_result, out_rd, exc_pc, br_target=0; out_reg_write=0.
//  Accept: in_valid & in_ready at posedge. Latency 1: accepted instr on out_* next cycle if empty.
//  Entries: main (drives out_*) and skid. Accept with main empty or leaving (out_valid&out_ready)
//   -> main; else -> skid. Main leaves with skid full -> skid moves to main same edge.
//  in_ready next = !skid_valid_next & !exc_valid_next. Never accept with skid full (no overflow).
//  Branch: on accept, br_taken=1 next cycle iff (in_br_eq & alu_iszero)|(in_br_ne & !alu_iszero);
//   br_target=in_br_target. Branch entries go downstream with out_reg_write=0.
//  Overflow: on accept with alu_overflow=1 -> exc_valid=1, exc_pc=in_pc; entry forwarded with
//   out_reg_write=0 (precise, no rd update). While exc_valid: in_ready=0. exc_ack clears next edge.
//   Second overflow impossible while exc_valid (no accepts).
//  flush: next edge both entries invalid, br_taken=0; any same-cycle accept dropped;
//   exc_valid and exc_pc unaffected (only exc_ack clears). flush has priority over accept/move.
//  Simultaneous exc_ack & flush: both apply. exc_ack with exc_valid=0: ignored.
//  out_* held stable while out_valid & !out_ready. Flags evaluated at accept; later ALU changes ignored.
//  rst_n low mid-transfer: entries and exception dropped immediately (async), in_ready=1 after release.
// STRUCTURE
//  Shared package alu_pkg: ALU command codes (ADD_=0..OR_=7), DW/RW defaults, entry-field widths.
//  One sub-module: ex_skid_buf (2-entry main/skid register pair with valid/ready, flush, param
//   payload width); ex_result_stage wraps it plus branch resolve and exception capture logic.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> out_valid=0, in_ready=1, exc_valid=0 without clock edge.
//  2 Stream: 4 ADDs result 1..4, out_ready=1 -> out_result 1,2,3,4 on consecutive cycles, lat 1.
//  3 Backpressure: out_ready=0, send 3 -> 2 held (main=1, skid=2), in_ready=0; release -> 1,2 in order, no loss/dup.
//  4 Branch: BEQ with iszero=1, target 0x40 -> br_taken pulse 1 cycle, br_target=0x40;
//   BNE with iszero=1 -> br_taken stays 0; both reach out with out_reg_write=0.
//  5 Overflow: ADD 0x7FFFFFFF+1, pc=0x100 -> exc_valid=1, exc_pc=0x100, out_reg_write=0,
//   in_ready=0 until exc_ack; in_ready=1 on the cycle after the exc_ack edge.
//  6 Flush: 2 entries held + in_valid same cycle -> next cycle out_valid=0, nothing emitted later.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU command codes, datapath widths and branch-resolve helper shared by the EX stage.
package alu_pkg;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int EW = DW + RW + 1;
    typedef enum logic [2:0] {
        ADD_ = 3'd0,
        SUB_ = 3'd1,
        AND_ = 3'd2,
        XOR_ = 3'd3,
        SLL_ = 3'd4,
        SRL_ = 3'd5,
        SRA_ = 3'd6,
        OR_  = 3'd7
    } alu_cmd_e;
    function automatic logic br_resolve(input logic eq, input logic ne, input logic zero);
        return (eq & zero) | (ne & !zero);
    endfunction
endpackage

// File: rtl/ex_result_stage_if.sv
// ex_result_stage_if: ALU-side input, MEM-side output, branch and exception signals of the EX stage.
interface ex_result_stage_if import alu_pkg::*; #(
    parameter int DW = alu_pkg::DW,
    parameter int RW = alu_pkg::RW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_result;
    logic          alu_iszero;
    logic          alu_overflow;
    logic [RW-1:0] in_rd;
    logic          in_reg_write;
    logic          in_br_eq;
    logic          in_br_ne;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_br_target;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_reg_write;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic          exc_valid;
    logic [DW-1:0] exc_pc;
    logic          exc_ack;
    modport slave (
        input  in_valid, alu_result, alu_iszero, alu_overflow, in_rd, in_reg_write,
               in_br_eq, in_br_ne, in_pc, in_br_target, flush, out_ready, exc_ack,
        output in_ready, out_valid, out_result, out_rd, out_reg_write,
               br_taken, br_target, exc_valid, exc_pc
    );
    modport master (
        output in_valid, alu_result, alu_iszero, alu_overflow, in_rd, in_reg_write,
               in_br_eq, in_br_ne, in_pc, in_br_target, flush, out_ready, exc_ack,
        input  in_ready, out_valid, out_result, out_rd, out_reg_write,
               br_taken, br_target, exc_valid, exc_pc
    );
endinterface

// File: rtl/ex_skid_buf.sv
// ex_skid_buf: 2-entry main/skid register pair; main drives the output, skid catches the
// one beat that can arrive after main stalls, so the upstream ready can stay registered.
module ex_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_stall_nxt,
    output logic         o_ready,
    output logic         o_accept,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_main_v;
    logic         r_skid_v;
    logic [W-1:0] r_main_d;
    logic [W-1:0] r_skid_d;
    logic         r_ready;
    logic         w_main_free;
    logic         w_main_v_nxt;
    logic         w_skid_v_nxt;
    logic         w_main_load;
    logic         w_skid_load;

    assign o_accept     = i_valid & r_ready & !i_flush;
    assign w_main_free  = !r_main_v | i_ready;
    // r_ready is low whenever skid is full, so accept and skid-full never coincide
    assign w_main_v_nxt = !i_flush & (w_main_free ? (r_skid_v | o_accept) : 1'b1);
    assign w_skid_v_nxt = !i_flush & !w_main_free & (r_skid_v | o_accept);
    assign w_main_load  = w_main_free & (r_skid_v | o_accept);
    assign w_skid_load  = !w_main_free & o_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_main_v <= w_main_v_nxt;
            r_skid_v <= w_skid_v_nxt;
            r_ready  <= !w_skid_v_nxt & !i_stall_nxt;
            if (w_main_load) r_main_d <= r_skid_v ? r_skid_d : i_data;
            if (w_skid_load) r_skid_d <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_v;
    assign o_data  = r_main_d;
endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: EX/MEM register stage behind the ALU; resolves BEQ/BNE and turns ADD
// overflow into a precise exception that blocks further accepts until acknowledged.
module ex_result_stage import alu_pkg::*; #(
    parameter int DW = alu_pkg::DW,
    parameter int RW = alu_pkg::RW
) (
    input logic               clk,
    input logic               rst_n,
    ex_result_stage_if.slave  bus
);
    localparam int EW = DW + RW + 1;

    logic          w_acc;
    logic          w_wr;
    logic          w_exc_nxt;
    logic [EW-1:0] w_in_d;
    logic [EW-1:0] w_out_d;
    logic          r_br_taken;
    logic [DW-1:0] r_br_target;
    logic          r_exc_valid;
    logic [DW-1:0] r_exc_pc;

    // branches and overflowing ADDs travel downstream but never update rd
    assign w_wr      = bus.in_reg_write & !bus.in_br_eq & !bus.in_br_ne & !bus.alu_overflow;
    assign w_in_d    = {bus.alu_result, bus.in_rd, w_wr};
    assign w_exc_nxt = (r_exc_valid & !bus.exc_ack) | (w_acc & bus.alu_overflow);

    ex_skid_buf #(.W(EW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (bus.flush),
        .i_valid     (bus.in_valid),
        .i_data      (w_in_d),
        .i_stall_nxt (w_exc_nxt),
        .o_ready     (bus.in_ready),
        .o_accept    (w_acc),
        .o_valid     (bus.out_valid),
        .i_ready     (bus.out_ready),
        .o_data      (w_out_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_exc_valid <= 1'b0;
            r_exc_pc    <= '0;
        end else begin
            r_br_taken  <= w_acc & br_resolve(bus.in_br_eq, bus.in_br_ne, bus.alu_iszero);
            r_exc_valid <= w_exc_nxt;
            if (w_acc) r_br_target <= bus.in_br_target;
            if (w_acc & bus.alu_overflow) r_exc_pc <= bus.in_pc;
        end
    end

    assign {bus.out_result, bus.out_rd, bus.out_reg_write} = w_out_d;
    assign bus.br_taken  = r_br_taken;
    assign bus.br_target = r_br_target;
    assign bus.exc_valid = r_exc_valid;
    assign bus.exc_pc    = r_exc_pc;
endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: directed checks of streaming, backpressure, branch, overflow, flush and reset.
module tb_ex_result_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ex_result_stage_if bus ();
    ex_result_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.alu_result = 0; bus.alu_iszero = 0; bus.alu_overflow = 0;
        bus.in_rd = 0; bus.in_reg_write = 0; bus.in_br_eq = 0; bus.in_br_ne = 0;
        bus.in_pc = 0; bus.in_br_target = 0;
    endtask

    task automatic send(input logic [31:0] res, input logic [4:0] rd, input logic [31:0] pc,
                        input logic eq, input logic ne, input logic z, input logic ov,
                        input logic [31:0] tgt);
        bus.in_valid = 1; bus.alu_result = res; bus.in_rd = rd; bus.in_reg_write = 1;
        bus.in_pc = pc; bus.in_br_eq = eq; bus.in_br_ne = ne; bus.alu_iszero = z;
        bus.alu_overflow = ov; bus.in_br_target = tgt;
    endtask

    initial begin
        idle();
        bus.flush = 0; bus.exc_ack = 0; bus.out_ready = 1;
        step(); step();
        rst_n = 1;
        step();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_exc_valid", bus.exc_valid, 0);
        chk("rst_br_taken", bus.br_taken, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_reg_write", bus.out_reg_write, 0);

        // stream of four ADDs, latency one
        for (int i = 1; i <= 4; i++) begin
            send(i, 5'(i), 32'h10 * i, 0, 0, 0, 0, 0);
            step();
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_result", bus.out_result, i);
            chk("stream_rd", bus.out_rd, i);
            chk("stream_wr", bus.out_reg_write, 1);
            chk("stream_ready", bus.in_ready, 1);
        end
        idle();
        step();
        chk("stream_drain", bus.out_valid, 0);

        // backpressure: main=1, skid=2, third held off
        bus.out_ready = 0;
        send(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("bp_ready1", bus.in_ready, 1);
        send(2, 2, 0, 0, 0, 0, 0, 0);
        step();
        chk("bp_ready2", bus.in_ready, 0);
        chk("bp_main", bus.out_result, 1);
        send(3, 3, 0, 0, 0, 0, 0, 0);
        step();
        chk("bp_hold_result", bus.out_result, 1);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_ready", bus.in_ready, 0);
        idle();
        bus.out_ready = 1;
        step();
        chk("bp_rel_first", bus.out_result, 2);
        chk("bp_rel_valid", bus.out_valid, 1);
        chk("bp_rel_ready", bus.in_ready, 1);
        step();
        chk("bp_empty", bus.out_valid, 0);

        // branches
        send(0, 7, 32'h20, 1, 0, 1, 0, 32'h40);
        step();
        chk("beq_taken", bus.br_taken, 1);
        chk("beq_target", bus.br_target, 32'h40);
        chk("beq_valid", bus.out_valid, 1);
        chk("beq_wr", bus.out_reg_write, 0);
        send(0, 8, 32'h24, 0, 1, 1, 0, 32'h80);
        step();
        chk("bne_not_taken", bus.br_taken, 0);
        chk("bne_valid", bus.out_valid, 1);
        chk("bne_wr", bus.out_reg_write, 0);
        idle();
        step();
        chk("br_idle", bus.br_taken, 0);

        // overflow exception
        send(32'h8000_0000, 9, 32'h100, 0, 0, 0, 1, 0);
        step();
        chk("ov_exc_valid", bus.exc_valid, 1);
        chk("ov_exc_pc", bus.exc_pc, 32'h100);
        chk("ov_wr", bus.out_reg_write, 0);
        chk("ov_result", bus.out_result, 32'h8000_0000);
        chk("ov_ready", bus.in_ready, 0);
        send(32'h55, 3, 32'h104, 0, 0, 0, 0, 0);
        step();
        chk("ov_blocked_ready", bus.in_ready, 0);
        chk("ov_blocked_valid", bus.out_valid, 0);
        chk("ov_still_exc", bus.exc_valid, 1);
        idle();
        bus.exc_ack = 1;
        step();
        bus.exc_ack = 0;
        chk("ack_exc_clear", bus.exc_valid, 0);
        chk("ack_ready", bus.in_ready, 1);

        // flush with two held entries and a same-cycle input
        bus.out_ready = 0;
        send(20, 1, 0, 0, 0, 0, 0, 0);
        step();
        send(21, 2, 0, 0, 0, 0, 0, 0);
        step();
        send(22, 3, 0, 0, 0, 0, 0, 0);
        bus.flush = 1;
        step();
        bus.flush = 0;
        idle();
        bus.out_ready = 1;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_ready", bus.in_ready, 1);
        step();
        chk("flush_nothing_later", bus.out_valid, 0);

        // flush drops an accept, including its branch pulse
        send(0, 4, 0, 1, 0, 1, 0, 32'h60);
        bus.flush = 1;
        step();
        bus.flush = 0;
        idle();
        chk("flush_acc_valid", bus.out_valid, 0);
        chk("flush_acc_br", bus.br_taken, 0);

        // flush leaves the exception alone; ack together with flush clears it
        send(32'h8000_0000, 5, 32'h200, 0, 0, 0, 1, 0);
        step();
        idle();
        bus.flush = 1;
        step();
        chk("flush_exc_kept", bus.exc_valid, 1);
        chk("flush_exc_pc", bus.exc_pc, 32'h200);
        chk("flush_exc_out", bus.out_valid, 0);
        bus.exc_ack = 1;
        step();
        bus.flush = 0; bus.exc_ack = 0;
        chk("ack_flush_clear", bus.exc_valid, 0);
        step();
        chk("ack_flush_ready", bus.in_ready, 1);

        // asynchronous reset mid-traffic
        bus.out_ready = 0;
        send(40, 1, 32'h300, 0, 0, 0, 1, 0);
        step();
        chk("pre_rst_exc", bus.exc_valid, 1);
        idle();
        #2 rst_n = 0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_in_ready", bus.in_ready, 1);
        chk("async_exc_valid", bus.exc_valid, 0);
        #1 rst_n = 1;
        step();
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_valid", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
